apb_host_bridge: RTL and testbench
==================================

APB_HOST_BRIDGE -- requirements
Module: apb_host_bridge

Interface
REQ-001 Parameter ADDR_W, default 3, sets the width of the APB address and the request address.
REQ-002 Parameter DATA_W, default 8, sets the width of the write data, read data and response data.
REQ-003 Parameter TIMEOUT_CYC, default 16, sets the number of ACCESS cycles allowed before timeout; legal range 1..255.
REQ-004 PCLK  in  1  single clock; all state changes on the rising edge.
REQ-005 PRESET  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  bridge accepts a request this cycle.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  target register address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  host consumes the response.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  transfer timed out.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-016 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address and write data.
REQ-017 PREADY  in  1; PRDATA  in  DATA_W  APB slave ready and read data.

Function
REQ-018 The FSM SHALL have four states, IDLE, SETUP, ACCESS and RESP; req_ready is 1 only in IDLE.
REQ-019 IDLE: when req_valid=1 at an edge, latch req_write, req_addr and req_wdata into PWRITE, PADDR and PWDATA, and go to SETUP.
REQ-020 SETUP SHALL last exactly one cycle (PSEL=1, PENABLE=0), ignore PREADY, and then go to ACCESS.
REQ-021 ACCESS SHALL hold PSEL=1 and PENABLE=1 until an edge with PREADY=1.
REQ-022 On that edge the bridge SHALL capture PRDATA into rsp_rdata for a read (0 for a write), clear PSEL and PENABLE, and go to RESP.
REQ-023 PADDR, PWDATA and PWRITE SHALL stay constant from SETUP through the last ACCESS cycle; after the transfer they hold their last values.
REQ-024 RESP: rsp_valid=1, with rsp_rdata and rsp_err stable, until an edge with rsp_ready=1; then rsp_valid=0 and the FSM returns to IDLE.
REQ-025 Minimum latency: request accepted at edge N gives SETUP in cycle N+1, ACCESS in N+2 and rsp_valid in N+3 when PREADY=1 in the first ACCESS cycle.
REQ-026 A request arriving outside IDLE SHALL be ignored until req_ready=1; the host holds it. No more than one transfer is ever outstanding.
REQ-027 PREADY=1 outside ACCESS SHALL have no effect.

Reset
REQ-028 With PRESET=1 at an edge, the FSM goes to IDLE and every output takes its reset value: req_ready=1 and all other outputs 0.
REQ-029 Reset in the middle of a transfer SHALL abandon it silently (no rsp_valid) and deassert PSEL and PENABLE on the same edge.

Configuration
REQ-030 With macro APB_HOST_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles.
REQ-031 With the macro defined, if PREADY is still 0 after TIMEOUT_CYC ACCESS cycles, the bridge ends the transfer: PSEL and PENABLE go to 0, rsp_err=1, rsp_rdata=0, and the FSM goes to RESP.
REQ-032 With the macro defined, PREADY=1 in exactly cycle TIMEOUT_CYC SHALL complete normally; the counter clears on entry to SETUP.
REQ-033 Without the macro, ACCESS waits indefinitely, rsp_err is tied to 0, no counter logic exists, and the port list is unchanged.

Structure
REQ-034 Package apb_host_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, RESP) and the ADDR_W and DATA_W default constants.
REQ-035 The timeout counter SHALL be sub-module apb_timeout_cnt, instantiated only under APB_HOST_TIMEOUT_EN, with counter width clog2(TIMEOUT_CYC+1).

Verification
REQ-036 Write addr=1, data=0x5A, PREADY=1 immediately -> SETUP 1 cycle, ACCESS 1 cycle with PADDR=1 and PWDATA=0x5A; rsp_valid at N+3, rsp_rdata=0x00, rsp_err=0.
REQ-037 Read addr=4, PRDATA=0xC3, PREADY delayed 5 cycles -> PENABLE high 6 cycles; rsp_rdata=0xC3.
REQ-038 rsp_ready held 0 for 4 cycles -> rsp_valid and data stable; a second req_valid is not accepted until IDLE.
REQ-039 PRESET=1 during ACCESS -> next edge PSEL=0, PENABLE=0, req_ready=1, and no response is produced.
REQ-040 With the macro, TIMEOUT_CYC=4 and PREADY stuck at 0 -> after 4 ACCESS cycles rsp_err=1 and rsp_rdata=0; without the macro PSEL stays high for 100 cycles.
REQ-041 With the macro, PREADY=1 in ACCESS cycle 4 with TIMEOUT_CYC=4 -> normal completion with rsp_err=0.

Source files
------------

// File: rtl/apb_host_pkg.sv
// apb_host_pkg
//   Shared definitions for the APB host bridge:
//     - state_e     : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//     - ADDR_W_DEF  : default APB / request address width
//     - DATA_W_DEF  : default write / read / response data width
package apb_host_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage : apb_host_pkg

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
//   Counts the ACCESS cycles of one APB transfer and flags the last cycle
//   that is still allowed before the bridge gives up on the slave.
//   Only instantiated when APB_HOST_TIMEOUT_EN is defined.
// Ports:
//   clk     in   bridge clock (PCLK)
//   rst     in   synchronous active-high reset
//   clr_i   in   clear the count (asserted on the edge that enters SETUP)
//   en_i    in   count this cycle (asserted while in ACCESS)
//   last_o  out  current ACCESS cycle is number TIMEOUT_CYC
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   // cnt_q holds the number of ACCESS cycles already completed, so the
   // cycle in progress is number cnt_q+1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, increment (saturating) or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CNT_LAST);

endmodule : apb_timeout_cnt

// File: rtl/apb_host_bridge.sv
// apb_host_bridge
//   Converts a valid/ready host request into a single APB transfer
//   (SETUP then ACCESS) and returns a valid/ready response. One transfer
//   is outstanding at most; every output is driven straight from a flop.
//   Optional: define APB_HOST_TIMEOUT_EN to end a transfer with rsp_err=1
//   when PREADY stays low for TIMEOUT_CYC ACCESS cycles.
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   req_valid/req_ready          host request handshake
//   req_write/req_addr/req_wdata host request payload
//   rsp_valid/rsp_ready          host response handshake
//   rsp_rdata/rsp_err            read data (0 for writes/errors), timeout flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB master outputs
//   PREADY/PRDATA                APB slave inputs
module apb_host_bridge
   import apb_host_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA
);

   state_e            state_q,     state_d;
   logic              req_ready_q, req_ready_d;
   logic              psel_q,      psel_d;
   logic              penable_q,   penable_d;
   logic              pwrite_q,    pwrite_d;
   logic [ADDR_W-1:0] paddr_q,     paddr_d;
   logic [DATA_W-1:0] pwdata_q,    pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_HOST_TIMEOUT_EN
   logic rsp_err_q, rsp_err_d;
   logic to_clr_s, to_en_s, to_last_s;

   // Restart the count on the edge that enters SETUP; count only in ACCESS.
   assign to_clr_s = (state_q == IDLE) && req_valid;
   assign to_en_s  = (state_q == ACCESS);

   apb_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_cnt (
      .clk    (PCLK),
      .rst    (PRESET),
      .clr_i  (to_clr_s),
      .en_i   (to_en_s),
      .last_o (to_last_s)
   );
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   // Next state and transfer/response payload.
   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_rdata_d = rsp_rdata_q;
`ifdef APB_HOST_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d  = SETUP;
               pwrite_d = req_write;
               paddr_d  = req_addr;
               pwdata_d = req_wdata;
            end else begin
               state_d  = IDLE;
            end
         end
         SETUP: begin
            // PREADY is deliberately not looked at here.
            state_d = ACCESS;
         end
         ACCESS: begin
            // A ready slave wins over a timeout in the same cycle.
            if (PREADY) begin
               state_d     = RESP;
               rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : PRDATA;
`ifdef APB_HOST_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (to_last_s) begin
               state_d     = RESP;
               rsp_rdata_d = {DATA_W{1'b0}};
               rsp_err_d   = 1'b1;
`endif
            end else begin
               state_d = ACCESS;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output flop inputs decoded from the next state so outputs are registered.
   always_comb begin
      req_ready_d = 1'b0;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      rsp_valid_d = 1'b0;
      case (state_d)
         IDLE: begin
            req_ready_d = 1'b1;
         end
         SETUP: begin
            psel_d = 1'b1;
         end
         ACCESS: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
         end
         RESP: begin
            rsp_valid_d = 1'b1;
         end
         default: begin
            req_ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= {ADDR_W{1'b0}};
         pwdata_q    <= {DATA_W{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
`ifdef APB_HOST_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_HOST_TIMEOUT_EN
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`ifdef APB_HOST_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule : apb_host_bridge

// File: tb/tb_apb_host_bridge.sv
// tb_apb_host_bridge
//   Directed scenarios plus randomized traffic for apb_host_bridge, checked
//   every cycle against a transfer-level reference model.
//   Honors APB_HOST_TIMEOUT_EN the same way the design does.
module tb_apb_host_bridge;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int TO = 4;
`ifdef APB_HOST_TIMEOUT_EN
   localparam bit TO_EN  = 1'b1;
   localparam int RD_DLY = 2;
`else
   localparam bit TO_EN  = 1'b0;
   localparam int RD_DLY = 5;
`endif

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          PSEL, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic          PREADY = 1'b0;
   logic [DW-1:0] PRDATA = '0;

   apb_host_bridge #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA)
   );

   always #5 PCLK = ~PCLK;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase of the single outstanding transfer
   // (0 no transfer, 1 setup, 2 access, 3 response waiting) and its payload.
   int            m_phase = 0;
   int            m_acc   = 0;
   bit            m_took  = 1'b0;
   logic          m_pwrite = 1'b0;
   logic [AW-1:0] m_paddr  = '0;
   logic [DW-1:0] m_pwdata = '0;
   logic [DW-1:0] m_rdata  = '0;
   logic          m_err    = 1'b0;

   always @(posedge PCLK) begin
      m_took = 1'b0;
      if (PRESET) begin
         m_phase = 0; m_acc = 0;
         m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_err = 1'b0;
      end else if (m_phase == 0) begin
         if (req_valid) begin
            m_took = 1'b1; m_phase = 1;
            m_pwrite = req_write; m_paddr = req_addr; m_pwdata = req_wdata;
         end
      end else if (m_phase == 1) begin
         m_phase = 2; m_acc = 0;
      end else if (m_phase == 2) begin
         m_acc = m_acc + 1;
         if (PREADY) begin
            m_phase = 3; m_err = 1'b0;
            m_rdata = m_pwrite ? 8'h00 : PRDATA;
         end else if (TO_EN && m_acc == TO) begin
            m_phase = 3; m_err = 1'b1; m_rdata = 8'h00;
         end
      end else if (rsp_ready) begin
         m_phase = 0;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge PCLK) begin
      if (chk_en) begin
         check("req_ready", {31'd0, req_ready}, {31'd0, m_phase == 0});
         check("PSEL",      {31'd0, PSEL},      {31'd0, (m_phase == 1) || (m_phase == 2)});
         check("PENABLE",   {31'd0, PENABLE},   {31'd0, m_phase == 2});
         check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == 3});
         check("PWRITE",    {31'd0, PWRITE},    {31'd0, m_pwrite});
         check("PADDR",     {29'd0, PADDR},     {29'd0, m_paddr});
         check("PWDATA",    {24'd0, PWDATA},    {24'd0, m_pwdata});
         if (m_phase == 3) begin
            check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m_rdata});
            check("rsp_err",   {31'd0, rsp_err},   {31'd0, m_err});
         end
      end
   end

   // One transfer from an idle bridge up to the first response cycle.
   // PREADY is raised in SETUP (must be ignored), then held low for dly
   // ACCESS cycles and raised in ACCESS cycle dly+1.
   task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int dly, output int pen, output int lat);
      @(negedge PCLK);
      check("idle_before_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      PRDATA = rd; PREADY = 1'b0; rsp_ready = 1'b0;
      @(negedge PCLK);
      req_valid = 1'b0; lat = 1; pen = 0;
      check("setup_psel",    {31'd0, PSEL},    32'd1);
      check("setup_penable", {31'd0, PENABLE}, 32'd0);
      PREADY = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge PCLK);
         lat++;
         if (rsp_valid) break;
         if (PENABLE) begin
            pen++;
            check("access_paddr",  {29'd0, PADDR},  {29'd0, a});
            check("access_pwdata", {24'd0, PWDATA}, {24'd0, wd});
            check("access_pwrite", {31'd0, PWRITE}, {31'd0, wr});
         end
         PREADY = (pen == dly + 1);
      end
      PREADY = 1'b0;
      check("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      check("rsp_consumed", {31'd0, rsp_valid}, 32'd0);
      check("back_to_idle", {31'd0, req_ready}, 32'd1);
   endtask

   int pen, lat, hi;

   initial begin
      repeat (2) @(negedge PCLK);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_psel",      {31'd0, PSEL},      32'd0);
      check("rst_penable",   {31'd0, PENABLE},   32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      check("rst_paddr",     {29'd0, PADDR},     32'd0);
      chk_en = 1'b1;
      PRESET = 1'b0;

      // Write, slave ready at once: response three cycles after acceptance.
      do_xfer(1'b1, 3'd1, 8'h5A, 8'hEE, 0, pen, lat);
      check("wr_latency", lat, 32'd3);
      check("wr_pen_cycles", pen, 32'd1);
      check("wr_rdata", {24'd0, rsp_rdata}, 32'h00);
      check("wr_err", {31'd0, rsp_err}, 32'd0);
      take_rsp();

      // Read with a slow slave.
      do_xfer(1'b0, 3'd4, 8'h11, 8'hC3, RD_DLY, pen, lat);
      check("rd_pen_cycles", pen, RD_DLY + 1);
      check("rd_rdata", {24'd0, rsp_rdata}, 32'hC3);
      // Host stalls the response while presenting a new request.
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd7; req_wdata = 8'hAA;
         @(negedge PCLK);
         check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("stall_rdata", {24'd0, rsp_rdata}, 32'hC3);
         check("stall_not_ready", {31'd0, req_ready}, 32'd0);
         check("stall_paddr", {29'd0, PADDR}, 32'd4);
      end
      req_valid = 1'b0;
      take_rsp();
      check("second_req_not_taken", {29'd0, PADDR}, 32'd4);

      // Reset in the middle of ACCESS.
      @(negedge PCLK);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
      @(negedge PCLK);
      req_valid = 1'b0; PREADY = 1'b0;
      @(negedge PCLK);
      check("pre_rst_penable", {31'd0, PENABLE}, 32'd1);
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      check("abort_psel", {31'd0, PSEL}, 32'd0);
      check("abort_penable", {31'd0, PENABLE}, 32'd0);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end

`ifdef APB_HOST_TIMEOUT_EN
      // Slave never ready: transfer ends after TO ACCESS cycles with an error.
      do_xfer(1'b0, 3'd3, 8'h00, 8'h77, 1000, pen, lat);
      check("to_pen_cycles", pen, TO);
      check("to_err", {31'd0, rsp_err}, 32'd1);
      check("to_rdata", {24'd0, rsp_rdata}, 32'h00);
      take_rsp();
`else
      // Slave never ready: ACCESS holds for as long as we care to watch.
      @(negedge PCLK);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd6;
      @(negedge PCLK);
      req_valid = 1'b0; PREADY = 1'b0;
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge PCLK);
         if (PSEL) hi++;
      end
      check("stuck_psel_cycles", hi, 32'd100);
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
`endif

      // Slave ready in exactly ACCESS cycle TO: normal completion.
      do_xfer(1'b0, 3'd5, 8'h00, 8'h3C, TO - 1, pen, lat);
      check("edge_pen_cycles", pen, TO);
      check("edge_err", {31'd0, rsp_err}, 32'd0);
      check("edge_rdata", {24'd0, rsp_rdata}, 32'h3C);
      take_rsp();

      // Randomized traffic; the host keeps a request until it is taken.
      for (int c = 0; c < 3000; c++) begin
         @(negedge PCLK);
         PRESET = ($urandom_range(0, 299) == 0);
         if (!req_valid || m_took) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
         end
         PREADY    = ($urandom_range(0, 2) == 0);
         PRDATA    = DW'($urandom);
         rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge PCLK);
      req_valid = 1'b0; PRESET = 1'b0;
      repeat (3) @(negedge PCLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_apb_host_bridge
